bcd_seg7_scan: RTL



---
 rtl/bcd_seg7_scan.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: display stage behind the 12-bit binary-to-BCD converter.
// Requests a conversion at regular intervals and latches the returned packed
// BCD. Drives a 4-digit common-anode multiplexed display with leading-zero
// blanking. A decimal point on the units digit marks stale data.
//
// Converter handshake: conv_en is a single-cycle request. The converter
// answers with a rising edge on bcd_rdy, and bcd_in is sampled on that edge.
// Only the rising edge counts, so a level held high captures exactly once.
// A rising edge is accepted in any state. Only one seen while waiting ends
// the request.
module bcd_seg7_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int UPDATE_TICKS = 1000,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        bcd_rdy,
    output logic        conv_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        stale
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int UPD_W = (UPDATE_TICKS > 1) ? $clog2(UPDATE_TICKS) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [DIV_W-1:0] div_cnt;
    logic [UPD_W-1:0] upd_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       state;
    logic [1:0]       digit_idx;
    logic [15:0]      held;
    logic             bcd_rdy_q;
    logic             tick;
    logic             rdy_rise;
    logic             blank3;
    logic             blank2;
    logic             blank1;
    logic [3:0]       cur_nib;
    logic             cur_blank;
    logic [6:0]       cur_seg;

    assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign rdy_rise = bcd_rdy & ~bcd_rdy_q;

    // Blanking ripples down from the thousands digit; units is never blanked.
    assign blank3 = (held[15:12] == 4'd0);
    assign blank2 = blank3 && (held[11:8] == 4'd0);
    assign blank1 = blank2 && (held[7:4] == 4'd0);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Select the nibble and blanking flag for the digit about to be shown.
    always_comb begin
        cur_nib   = held[3:0];
        cur_blank = 1'b0;
        case (digit_idx)
            2'd0: begin cur_nib = held[3:0];   cur_blank = 1'b0;   end
            2'd1: begin cur_nib = held[7:4];   cur_blank = blank1; end
            2'd2: begin cur_nib = held[11:8];  cur_blank = blank2; end
            default: begin cur_nib = held[15:12]; cur_blank = blank3; end
        endcase
        cur_seg = cur_blank ? 7'h7F : seg_decode(cur_nib);
    end

    // Scan divider: free-running 0..SCAN_DIV-1, tick on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // On each tick show the current digit, then advance to the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx <= 2'd0;
            an        <= 4'b1111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else if (tick) begin
            an        <= ~(4'b0001 << digit_idx);
            seg       <= cur_seg;
            dp        <= ~((digit_idx == 2'd0) && stale);
            digit_idx <= digit_idx + 2'd1;
        end
    end

    // Ready edge detector and result capture, independent of request state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_rdy_q <= 1'b0;
            held      <= 16'h0000;
        end else begin
            bcd_rdy_q <= bcd_rdy;
            if (rdy_rise) begin
                held <= bcd_in;
            end
        end
    end

    // Request FSM: idle for UPDATE_TICKS ticks, pulse conv_en, then wait
    // for the ready edge or give up after TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            upd_cnt <= '0;
            to_cnt  <= '0;
            conv_en <= 1'b0;
            stale   <= 1'b0;
        end else begin
            conv_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        if (upd_cnt == UPD_W'(UPDATE_TICKS - 1)) begin
                            upd_cnt <= '0;
                            conv_en <= 1'b1;
                            state   <= S_REQ;
                        end else begin
                            upd_cnt <= upd_cnt + UPD_W'(1);
                        end
                    end
                end
                S_REQ: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // A ready edge in the expiry cycle still counts as an answer.
                    if (rdy_rise) begin
                        stale <= 1'b0;
                        state <= S_IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        stale <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
